uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  UART receive controller: start detect, frame FSM, 3-point majority sampling, deserialization,
//  parity/stop checking. Drives cnt_enable of edge_counter and consumes its edge_cnt/bit_cnt.
//  8x oversampled: one bit = 8 CLK cycles (edge_cnt 0..7). Output feeds RX data sync/FIFO stage.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, LSB first; legal range 5..8
// PORTS
//  CLK         in   1           oversampling clock (8x baud)
//  RST         in   1           asynchronous, active-low reset
//  RX_IN       in   1           serial line, already synchronized to CLK; idle high
//  PAR_EN      in   1           1 = parity bit present
//  PAR_TYP     in   1           0 = even, 1 = odd
//  edge_cnt    in   3           from edge_counter
//  bit_cnt     in   4           from edge_counter
//  cnt_enable  out  1           enable to edge_counter
//  P_DATA      out  DATA_WIDTH  received word
//  data_valid  out  1           1-cycle pulse, P_DATA valid
//  par_err     out  1           parity error of last frame
//  stp_err     out  1           stop error of last frame
//  strt_glitch out  1           1-cycle pulse, false start rejected
// BEHAVIOUR
//  Reset: state=IDLE; P_DATA=0, data_valid=0, par_err=0, stp_err=0, strt_glitch=0, shift reg=0,
//   samples=0, latched parity cfg=0. Reset mid-frame aborts frame; no flag/pulse emitted.
//  cnt_enable = (state != IDLE), combinational from state register.
//  Sampler: RX_IN captured at edge_cnt 3,4,5 into s[2:0]; bit value maj = majority(s).
//   All bit decisions taken on the cycle edge_cnt==7 ("bit end").
//  FSM (all transitions on rising CLK):
//   IDLE   : RX_IN==0 -> START; latch PAR_EN/PAR_TYP; clear par_err, stp_err.
//   START  : bit end: maj==0 -> DATA; maj==1 -> IDLE, strt_glitch=1 for one cycle.
//   DATA   : bit end: shreg <= {maj, shreg[DATA_WIDTH-1:1]};
//            bit_cnt==DATA_WIDTH -> PARITY if latched PAR_EN else STOP.
//   PARITY : bit end: par_err <= maj ^ (^shreg) ^ latched PAR_TYP; -> STOP.
//   STOP   : bit end: stp_err <= ~maj; if no par/stp error then P_DATA <= shreg and data_valid=1
//            for one cycle; -> IDLE regardless of errors.
//  P_DATA holds last good word; unchanged on errored frame. par_err/stp_err hold until next START.
//  PAR_EN/PAR_TYP changes mid-frame ignored (latched copy used).
//  Latency: data_valid rises 80 CLK edges after the edge sampling RX_IN low (88 with parity).
//  Back-to-back: STOP->IDLE edge leaves counters stale one cycle; IDLE (enable=0) clears them,
//   so a start bit immediately after stop begins at edge_cnt=0, bit_cnt=0. No frame lost.
//  Stop bit low: frame flagged, FSM still returns to IDLE; low line re-triggers START and is
//   filtered by start glitch check if it does not persist.
// TESTING
//  No parity, send 0xA5, 1 stop -> data_valid 1 cycle at edge 80, P_DATA=0xA5, errors 0.
//  PAR_EN=1 even, 0x3C parity 0 -> P_DATA=0x3C, par_err=0; same frame parity 1 -> par_err=1, no valid.
//  PAR_EN=1 odd, 0x01 parity 0 -> valid, P_DATA=0x01; stop bit forced 0 -> stp_err=1, P_DATA unchanged.
//  RX_IN low 2 cycles then high -> strt_glitch pulse at start bit end, state IDLE, no valid.
//  Two frames 0x55,0xAA with zero idle gap -> two valid pulses 80 cycles apart, both correct.
//  RST low during DATA bit 4 -> all outputs 0, cnt_enable 0; next clean frame 0x0F received.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, frame FSM, 3-point majority sampling,
// LSB-first deserialization and parity/stop checking on an 8x oversampled line.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [2:0]            edge_cnt,
    input  logic [3:0]            bit_cnt,
    output logic                  cnt_enable,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch
);

    localparam int unsigned EDGE_W    = 3;
    localparam int unsigned BIT_W     = 4;
    localparam int unsigned SAMP_0    = 3;
    localparam int unsigned SAMP_1    = 4;
    localparam int unsigned SAMP_2    = 5;
    localparam int unsigned EDGE_LAST = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shreg_nxt;
    logic [2:0]            r_samp;
    logic [2:0]            w_samp_nxt;
    logic                  r_par_en;
    logic                  w_par_en_nxt;
    logic                  r_par_typ;
    logic                  w_par_typ_nxt;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic [DATA_WIDTH-1:0] w_p_data_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic                  r_par_err;
    logic                  w_par_err_nxt;
    logic                  r_stp_err;
    logic                  w_stp_err_nxt;
    logic                  r_glitch;
    logic                  w_glitch_nxt;
    logic                  w_maj;
    logic                  w_bit_end;

    assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
    assign w_bit_end = (edge_cnt == EDGE_W'(EDGE_LAST));

    assign cnt_enable  = (r_state != IDLE);
    assign P_DATA      = r_p_data;
    assign data_valid  = r_valid;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;
    assign strt_glitch = r_glitch;

    // Next-state, sampler and datapath updates; every bit decision waits for bit end.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_samp_nxt    = r_samp;
        w_par_en_nxt  = r_par_en;
        w_par_typ_nxt = r_par_typ;
        w_p_data_nxt  = r_p_data;
        w_valid_nxt   = 1'b0;
        w_glitch_nxt  = 1'b0;
        w_par_err_nxt = r_par_err;
        w_stp_err_nxt = r_stp_err;

        if (edge_cnt == EDGE_W'(SAMP_0)) w_samp_nxt[0] = RX_IN;
        if (edge_cnt == EDGE_W'(SAMP_1)) w_samp_nxt[1] = RX_IN;
        if (edge_cnt == EDGE_W'(SAMP_2)) w_samp_nxt[2] = RX_IN;

        case (r_state)
            IDLE: begin
                if (!RX_IN) begin
                    w_state_nxt   = START;
                    w_par_en_nxt  = PAR_EN;
                    w_par_typ_nxt = PAR_TYP;
                    w_par_err_nxt = 1'b0;
                    w_stp_err_nxt = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    if (w_maj) begin
                        w_state_nxt  = IDLE;
                        w_glitch_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shreg_nxt = {w_maj, r_shreg[DATA_WIDTH-1:1]};
                    if (bit_cnt == BIT_W'(DATA_WIDTH)) begin
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_par_err_nxt = w_maj ^ (^r_shreg) ^ r_par_typ;
                    w_state_nxt   = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_stp_err_nxt = ~w_maj;
                    if (!r_par_err && w_maj) begin
                        w_p_data_nxt = r_shreg;
                        w_valid_nxt  = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_samp    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_p_data  <= '0;
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
            r_glitch  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_samp    <= w_samp_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_typ <= w_par_typ_nxt;
            r_p_data  <= w_p_data_nxt;
            r_valid   <= w_valid_nxt;
            r_par_err <= w_par_err_nxt;
            r_stp_err <= w_stp_err_nxt;
            r_glitch  <= w_glitch_nxt;
        end
    end

endmodule
